// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// ----------------
// Parametrised register chain with a valid/ready handshake at each end.
// It collapses bubbles, has a synchronous flush, and reports how many words it holds.
// Each stage carries its own valid bit, so the handshake provides stall and the
// flush input provides clear.
//
// Optional feature macro: PIPE_SKID_EN
//   undefined : one register per stage. The ready signal is chained
//               combinationally from out_ready back to in_ready.
//               Capacity is STAGES.
//   defined   : each stage has a one-entry skid register behind its main
//               register. Stage ready is registered (skid empty).
//               Capacity is 2*STAGES. Latency is the same as without skid.
//
// Parameters
//   WIDTH   data bits per stage
//   STAGES  number of register stages (1..8)
//   CNT_W   width of the occupancy count
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous discard of every held entry
//   in_valid   upstream has data
//   in_ready   chain accepts in_data this cycle
//   in_data    upstream data
//   out_valid  last stage holds data
//   out_ready  downstream accepts
//   out_data   last-stage data (zero when empty)
//   count      number of entries currently held
module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = $clog2(2*STAGES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] stage_v;      // main-register valid per stage
    logic [STAGES-1:0] stage_rdy;    // stage can take a word this edge
    logic [STAGES-1:0] stage_leave;  // stage's main content moves on this edge
    logic [STAGES-1:0] up_valid;     // word presented to each stage this edge
    logic [WIDTH-1:0]  stage_d  [STAGES];
    logic [WIDTH-1:0]  up_data  [STAGES];
    logic              in_fire;
    logic              out_fire;
    logic [CNT_W-1:0]  count_reg;

`ifdef PIPE_SKID_EN
    logic [STAGES-1:0] skid_v;
    logic [STAGES:0]   down_rdy;     // ready seen by each stage from downstream

    // Ready comes only from registers. A stage can take a word while its skid is free.
    assign stage_rdy   = ~skid_v;
    assign down_rdy    = {out_ready, stage_rdy};
    assign stage_leave = stage_v & down_rdy[STAGES:1];
`else
    logic chain_rdy;

    // Walk from the output back to the input. A stage is ready when it is empty
    // or its word leaves this edge. This creates the combinational out_ready -> in_ready path.
    always_comb begin
        stage_rdy   = '0;
        stage_leave = '0;
        chain_rdy   = out_ready;
        for (int i = LAST; i >= 0; i--) begin
            stage_leave[i] = stage_v[i] && chain_rdy;
            stage_rdy[i]   = !stage_v[i] || stage_leave[i];
            chain_rdy      = stage_rdy[i];
        end
    end
`endif

    // While reset is held, no input is taken. No input is taken during a flush cycle either.
    assign in_ready  = rst && !flush && stage_rdy[0];
    assign in_fire   = in_valid && in_ready;
    assign out_valid = stage_v[LAST];
    assign out_data  = stage_d[LAST];
    assign out_fire  = out_valid && out_ready;
    assign count     = count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             v_reg;
            logic [WIDTH-1:0] d_reg;

            if (gi == 0) begin : g_src_in
                assign up_valid[gi] = in_fire;
                assign up_data[gi]  = in_data;
            end else begin : g_src_prev
                assign up_valid[gi] = stage_leave[gi-1];
                assign up_data[gi]  = stage_d[gi-1];
            end

            assign stage_v[gi] = v_reg;
            assign stage_d[gi] = d_reg;

`ifdef PIPE_SKID_EN
            logic             sv_reg;
            logic [WIDTH-1:0] sd_reg;

            assign skid_v[gi] = sv_reg;

            // When the skid is full, the stage takes no input (ready is low).
            // The skid refills main as soon as main leaves, so order is kept.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_reg  <= 1'b0;
                    d_reg  <= '0;
                    sv_reg <= 1'b0;
                    sd_reg <= '0;
                end else if (flush) begin
                    v_reg  <= 1'b0;
                    d_reg  <= '0;
                    sv_reg <= 1'b0;
                    sd_reg <= '0;
                end else if (sv_reg) begin
                    if (stage_leave[gi]) begin
                        v_reg  <= 1'b1;
                        d_reg  <= sd_reg;
                        sv_reg <= 1'b0;
                        sd_reg <= '0;
                    end
                end else if (up_valid[gi]) begin
                    if (!v_reg || stage_leave[gi]) begin
                        v_reg <= 1'b1;
                        d_reg <= up_data[gi];
                    end else begin
                        sv_reg <= 1'b1;
                        sd_reg <= up_data[gi];
                    end
                end else if (stage_leave[gi]) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                end
            end
`else
            // A ready stage is either empty or emptying. It reloads from upstream,
            // or it goes empty with its data cleared to zero.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                end else if (flush) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                end else if (stage_rdy[gi]) begin
                    v_reg <= up_valid[gi];
                    d_reg <= up_valid[gi] ? up_data[gi] : '0;
                end
            end
`endif
        end
    endgenerate

    // Occupancy count. The flush clears it even if a word also leaves on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain.
// The bench runs a per-cycle vector table of inputs plus expected ready, valid,
// data and count. A scoreboard queue checks the order of data words.
// A hand-written sequence covers asynchronous reset mid-stream and the nominal
// latency after reset is released.
module tb_pipe_stage_chain;

    localparam int WIDTH = 32;
`ifdef PIPE_SKID_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 3;
`endif
    localparam int CNT_W = $clog2(2*STAGES+1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] sb_q[$];

    typedef struct {
        int iv;
        int din;
        int ordy;
        int fl;
        int eir;
        int eov;
        int eod;
        int ecnt;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int iv, input int din, input int ordy, input int fl,
                       input int eir, input int eov, input int eod, input int ecnt);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.eir = eir; v.eov = eov; v.eod = eod; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    // Called mid-cycle, after the inputs are stable and before the edge.
    task automatic sample_sb();
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got 0x%0h expected no word", out_data);
            end else begin
                check("sb_data", out_data, sb_q.pop_front());
            end
        end
        if (in_valid && in_ready) sb_q.push_back(in_data);
        if (flush) sb_q.delete();
    endtask

    int lat;

    initial begin
        // Reset state while rst is held low.
        #3;
        check("rst in_ready", 32'(in_ready), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_data", out_data, 0);
        check("rst count", 32'(count), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef PIPE_SKID_EN
        // Skid build, STAGES=2: four words held under backpressure, then drained.
        add(1, 1, 0, 0, 1, 0, 0, 0);
        add(1, 2, 0, 0, 1, 0, 0, 1);
        add(1, 3, 0, 0, 1, 1, 1, 2);
        add(1, 4, 0, 0, 1, 1, 1, 3);
        add(1, 5, 0, 0, 0, 1, 1, 4);
        add(1, 5, 1, 0, 0, 1, 1, 4);
        add(0, 0, 1, 0, 0, 1, 2, 3);
        add(0, 0, 1, 0, 1, 1, 3, 2);
        add(0, 0, 1, 0, 1, 1, 4, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);
`else
        // Stream 1..8 with out_ready high. The first word appears 2 edges after acceptance.
        for (int i = 0; i < 8; i++)
            add(1, i + 1, 1, 0, 1, (i >= 3) ? 1 : 0, (i >= 3) ? i - 2 : 0, (i < 3) ? i : 3);
        add(0, 0, 1, 0, 1, 1, 6, 3);
        add(0, 0, 1, 0, 1, 1, 7, 2);
        add(0, 0, 1, 0, 1, 1, 8, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        // Backpressure: A,B,C accepted, D held off until out_ready returns.
        add(1, 'hA, 0, 0, 1, 0, 0, 0);
        add(1, 'hB, 0, 0, 1, 0, 0, 1);
        add(1, 'hC, 0, 0, 1, 0, 0, 2);
        add(1, 'hD, 0, 0, 0, 1, 'hA, 3);
        add(1, 'hD, 0, 0, 0, 1, 'hA, 3);
        add(1, 'hD, 1, 0, 1, 1, 'hA, 3);
        add(0, 0, 1, 0, 1, 1, 'hB, 3);
        add(0, 0, 1, 0, 1, 1, 'hC, 2);
        add(0, 0, 1, 0, 1, 1, 'hD, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        // Flush on a full chain: 0x11 is delivered, 0x44 is rejected, everything is cleared.
        add(1, 'h11, 0, 0, 1, 0, 0, 0);
        add(1, 'h22, 0, 0, 1, 0, 0, 1);
        add(1, 'h33, 0, 0, 1, 0, 0, 2);
        add(1, 'h44, 1, 1, 0, 1, 'h11, 3);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        // Bubble collapse: 0x55 is held in the last stage and 0x66 is still accepted.
        add(1, 'h55, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(1, 'h66, 0, 0, 1, 1, 'h55, 1);
        add(0, 0, 0, 0, 1, 1, 'h55, 2);
        add(0, 0, 1, 0, 1, 1, 'h55, 2);
        add(0, 0, 1, 0, 1, 1, 'h66, 1);
        add(0, 0, 1, 0, 1, 0, 0, 0);
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            in_valid  = (vecs[k].iv != 0);
            in_data   = vecs[k].din;
            out_ready = (vecs[k].ordy != 0);
            flush     = (vecs[k].fl != 0);
`ifdef PIPE_SKID_EN
            // in_ready must not react to out_ready within the same cycle.
            #1;
            out_ready = (vecs[k].ordy == 0);
            #1;
            check($sformatf("row%0d in_ready_vs_out_ready", k), 32'(in_ready), vecs[k].eir);
            out_ready = (vecs[k].ordy != 0);
`endif
            @(negedge clk);
            check($sformatf("row%0d in_ready", k), 32'(in_ready), vecs[k].eir);
            check($sformatf("row%0d out_valid", k), 32'(out_valid), vecs[k].eov);
            check($sformatf("row%0d out_data", k), out_data, vecs[k].eod);
            check($sformatf("row%0d count", k), 32'(count), vecs[k].ecnt);
            $display("row %0d: iv=%0d din=0x%0h ordy=%0d flush=%0d -> ir=%0d ov=%0d od=0x%0h cnt=%0d",
                     k, in_valid, in_data, out_ready, flush, in_ready, out_valid, out_data, count);
            sample_sb();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h91 + 32'(i);
            @(negedge clk);
            sample_sb();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre_rst out_valid", 32'(out_valid), 1);
        check("pre_rst count", 32'(count), 3);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst out_valid", 32'(out_valid), 0);
        check("async_rst count", 32'(count), 0);
        check("async_rst out_data", out_data, 0);
        check("async_rst in_ready", 32'(in_ready), 0);
        $display("reset asserted mid-cycle: ov=%0d cnt=%0d od=0x%0h", out_valid, count, out_data);
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // A single word after reset release should see nominal latency.
        in_valid  = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst in_ready", 32'(in_ready), 1);
        sample_sb();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                sample_sb();
                break;
            end
            @(posedge clk);
            #1;
        end
        check("post_rst latency", 32'(lat), 32'(STAGES));
        $display("post-reset word 0x77 seen after %0d cycles", lat);
        @(posedge clk);
        #1;
        check("final count", 32'(count), 0);
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
